// File: rtl/fft_sample_loader.sv
// Brings SPI bytes into the clk domain, pairs them into 16-bit samples and fills the FFT buffer.
// Optional `FFT_BITREV_ADDR_EN: write addresses are bit-reversed (decimation-in-time order).
module fft_sample_loader #(
  parameter int unsigned FFT_SIZE = 32,
  parameter int unsigned ADDR_W   = $clog2(FFT_SIZE)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              received_wd_i,
  input  logic [7:0]        sample_in_i,
  input  logic              cs_i,
  input  logic              frame_ack_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              frame_valid_o,
  output logic              overflow_o
);

  typedef enum logic [0:0] {StFill, StWaitAck} state_e;

  state_e            state_q, state_d;
  logic [2:0]        rwd_q;
  logic [1:0]        cs_q;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overflow_q, overflow_d;
  logic              byte_stb;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] r;
`ifdef FFT_BITREV_ADDR_EN
    for (int i = 0; i < int'(ADDR_W); i++) r[i] = c[int'(ADDR_W)-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  // sample_in_i is used unsynchronized: it is stable long before byte_stb fires.
  assign byte_stb = rwd_q[1] & ~rwd_q[2];

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    count_d       = count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_valid_d = frame_valid_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      StFill: begin
        if (byte_stb) begin
          if (!phase_q) begin
            hi_d    = sample_in_i;
            phase_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = map_addr(count_q);
            wr_data_d = {hi_q, sample_in_i};
            phase_d   = 1'b0;
            if (count_q == ADDR_W'(FFT_SIZE - 1)) begin
              count_d       = '0;
              state_d       = StWaitAck;
              frame_valid_d = 1'b1;
            end else begin
              count_d = count_q + ADDR_W'(1);
            end
          end
        end
      end
      StWaitAck: begin
        if (frame_ack_i) begin
          state_d       = StFill;
          frame_valid_d = 1'b0;
          phase_d       = 1'b0;
          // A byte arriving with the ack opens the next frame instead of being dropped.
          if (byte_stb) begin
            hi_d    = sample_in_i;
            phase_d = 1'b1;
          end
        end else if (byte_stb) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase

    // Deselect realigns byte pairing; sample count is kept.
    if (cs_q[1]) phase_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StFill;
      rwd_q         <= '0;
      cs_q          <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      count_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rwd_q         <= {rwd_q[1:0], received_wd_i};
      cs_q          <= {cs_q[0], cs_i};
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      count_q       <= count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign frame_valid_o = frame_valid_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with FFT_SIZE=32; honours `FFT_BITREV_ADDR_EN.
module tb_fft_sample_loader;

  localparam int unsigned FftSize = 32;
  localparam int unsigned AddrW   = 5;

  logic             clk;
  logic             reset;
  logic             received_wd;
  logic [7:0]       sample_in;
  logic             cs;
  logic             frame_ack;
  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [15:0]      wr_data;
  logic             frame_valid;
  logic             overflow;

  int tests_run = 0;
  int tests_failed = 0;

  int               wr_cnt = 0;
  logic [AddrW-1:0] addr_log [128];
  logic [15:0]      data_log [128];

  fft_sample_loader #(
    .FFT_SIZE(FftSize),
    .ADDR_W  (AddrW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .received_wd_i(received_wd),
    .sample_in_i  (sample_in),
    .cs_i         (cs),
    .frame_ack_i  (frame_ack),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .frame_valid_o(frame_valid),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log[wr_cnt % 128] = wr_addr;
      data_log[wr_cnt % 128] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  function automatic logic [AddrW-1:0] exp_addr(input int k);
    logic [AddrW-1:0] c;
    logic [AddrW-1:0] r;
    c = AddrW'(k);
`ifdef FFT_BITREV_ADDR_EN
    for (int i = 0; i < int'(AddrW); i++) r[i] = c[int'(AddrW)-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    sample_in   = b;
    received_wd = 1'b1;
    repeat (4) @(negedge clk);
    received_wd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raises frame_ack exactly on the cycle the resulting byte strobe is seen.
  task automatic send_byte_with_ack(input logic [7:0] b);
    @(negedge clk);
    sample_in   = b;
    received_wd = 1'b1;
    repeat (2) @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
    received_wd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_frame();
    for (int k = 0; k < int'(FftSize); k++) begin
      send_byte(8'(k));
      send_byte(~8'(k));
    end
  endtask

  int base;

  initial begin
    reset       = 1'b1;
    received_wd = 1'b0;
    sample_in   = 8'h00;
    cs          = 1'b0;
    frame_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First sample
    base = wr_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    check("first_nwrites", 32'(wr_cnt - base), 32'd1);
    check("first_addr", 32'(addr_log[base % 128]), 32'(exp_addr(0)));
    check("first_data", 32'(data_log[base % 128]), 32'h1234);
    check("first_frame_valid", 32'(frame_valid), 32'd0);

    // Reset after 5 samples
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hA0);
      send_byte(8'(k));
    end
    send_byte(8'hEE);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_wr_en", 32'(wr_en), 32'd0);
    check("midreset_wr_addr", 32'(wr_addr), 32'd0);
    check("midreset_wr_data", 32'(wr_data), 32'd0);
    check("midreset_frame_valid", 32'(frame_valid), 32'd0);
    check("midreset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    send_byte(8'h55);
    send_byte(8'h66);
    check("postreset_nwrites", 32'(wr_cnt - base), 32'd1);
    check("postreset_addr", 32'(addr_log[base % 128]), 32'(exp_addr(0)));
    check("postreset_data", 32'(data_log[base % 128]), 32'h5566);

    // Full frame: sample k = {k, ~k}
    do_reset();
    base = wr_cnt;
    for (int k = 0; k < int'(FftSize) - 1; k++) begin
      send_byte(8'(k));
      send_byte(~8'(k));
    end
    check("frame_valid_before_last", 32'(frame_valid), 32'd0);
    send_byte(8'(FftSize - 1));
    send_byte(~8'(FftSize - 1));
    check("frame_nwrites", 32'(wr_cnt - base), 32'(FftSize));
    for (int k = 0; k < int'(FftSize); k++) begin
      check($sformatf("frame_addr_%0d", k), 32'(addr_log[(base + k) % 128]), 32'(exp_addr(k)));
      check($sformatf("frame_data_%0d", k), 32'(data_log[(base + k) % 128]),
            32'({8'(k), ~8'(k)}));
    end
    check("frame_valid_full", 32'(frame_valid), 32'd1);

    // Bytes during WAIT_ACK are dropped
    base = wr_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    check("drop_nwrites", 32'(wr_cnt - base), 32'd0);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_frame_valid", 32'(frame_valid), 32'd1);
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check("ack_frame_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    check("ack_overflow_sticky", 32'(overflow), 32'd1);
    base = wr_cnt;
    send_byte(8'h9A);
    send_byte(8'hBC);
    check("after_ack_nwrites", 32'(wr_cnt - base), 32'd1);
    check("after_ack_addr", 32'(addr_log[base % 128]), 32'(exp_addr(0)));
    check("after_ack_data", 32'(data_log[base % 128]), 32'h9ABC);
    check("after_ack_overflow", 32'(overflow), 32'd1);

    // Ack coincident with a byte strobe
    do_reset();
    fill_frame();
    check("coin_frame_valid_pre", 32'(frame_valid), 32'd1);
    base = wr_cnt;
    send_byte_with_ack(8'hAB);
    check("coin_frame_valid_post", 32'(frame_valid), 32'd0);
    send_byte(8'hCD);
    check("coin_nwrites", 32'(wr_cnt - base), 32'd1);
    check("coin_addr", 32'(addr_log[base % 128]), 32'(exp_addr(0)));
    check("coin_data", 32'(data_log[base % 128]), 32'hABCD);
    check("coin_overflow", 32'(overflow), 32'd0);

    // Chip-select deassertion discards a held high byte
    base = wr_cnt;
    send_byte(8'h77);
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h02);
    check("cs_nwrites", 32'(wr_cnt - base), 32'd1);
    check("cs_addr", 32'(addr_log[base % 128]), 32'(exp_addr(1)));
    check("cs_data", 32'(data_log[base % 128]), 32'h0102);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
